mem_stage_param: RTL and testbench

MEM_STAGE_PARAM -- requirements
Module: mem_stage_param

---
 rtl/mem_stage_param.sv | 156 +++++++++++++++
 tb/tb_mem_stage_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_param.sv
// MEM stage: DEPTH-word data memory, WAIT_CYCLES stall FSM, byte/half/word access.
// Optional misalignment trap enabled with macro MEM_MISALIGN_TRAP_EN.
module mem_stage_param #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_MEM_valid,
  input  logic        EX_MEM_mem_to_reg,
  input  logic        EX_MEM_reg_write,
  input  logic        EX_MEM_mem_read,
  input  logic        EX_MEM_mem_write,
  input  logic [2:0]  EX_MEM_funct3,
  input  logic [31:0] EX_MEM_alu_out,
  input  logic [31:0] EX_MEM_dataB,
  input  logic [4:0]  EX_MEM_rd,
  output logic        mem_stall,
  output logic        MEM_WB_valid,
  output logic        MEM_WB_mem_to_reg,
  output logic        MEM_WB_reg_write,
  output logic [31:0] MEM_WB_mem_data,
  output logic [31:0] MEM_WB_alu_out,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    ofs;
  logic          mem_op, is_load, is_store, mis, done;
  logic [31:0]   rword, ldata, wdata;
  logic [3:0]    be;
  logic [7:0]    lbyte;
  logic [15:0]   lhalf;

  assign idx      = EX_MEM_alu_out[AW+1:2];
  assign ofs      = EX_MEM_alu_out[1:0];
  assign mem_op   = EX_MEM_valid & (EX_MEM_mem_read | EX_MEM_mem_write);
  assign is_store = EX_MEM_valid & EX_MEM_mem_write;
  assign is_load  = EX_MEM_valid & EX_MEM_mem_read & ~EX_MEM_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = mem_op & ((EX_MEM_funct3[1:0] == 2'b01 & ofs[0])
                       | (EX_MEM_funct3[1] & (ofs != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign rword = mem[idx];
  assign lbyte = 8'(rword >> {ofs, 3'b000});
  assign lhalf = ofs[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ldata = rword;
    wdata = EX_MEM_dataB;
    be    = 4'b1111;
    unique case (1'b1)
      EX_MEM_funct3[1:0] == 2'b00: begin
        ldata = EX_MEM_funct3[2] ? {24'd0, lbyte}
                                 : {{24{lbyte[7]}}, lbyte};
        wdata = {4{EX_MEM_dataB[7:0]}};
        be    = 4'b0001 << ofs;
      end
      EX_MEM_funct3[1:0] == 2'b01: begin
        ldata = EX_MEM_funct3[2] ? {16'd0, lhalf}
                                 : {{16{lhalf[15]}}, lhalf};
        wdata = {2{EX_MEM_dataB[15:0]}};
        be    = ofs[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // A stalled access reports done only on its final WAIT cycle.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    done      = 1'b0;
    mem_stall = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mem_op && !mis && WAIT_CYCLES != 0) begin
          mem_stall = 1'b1;
          cnt_n     = WC - 4'd1;
          state_n   = S_WAIT;
        end else begin
          done = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          mem_stall = 1'b1;
          cnt_n     = cnt - 4'd1;
        end else begin
          done    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (reset) mem_stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      cnt               <= 4'd0;
      MEM_WB_valid      <= 1'b0;
      MEM_WB_mem_to_reg <= 1'b0;
      MEM_WB_reg_write  <= 1'b0;
      MEM_WB_mem_data   <= 32'd0;
      MEM_WB_alu_out    <= 32'd0;
      MEM_WB_rd         <= 5'd0;
      MEM_WB_misalign   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (done) begin
        MEM_WB_valid      <= EX_MEM_valid;
        MEM_WB_mem_to_reg <= EX_MEM_mem_to_reg;
        MEM_WB_reg_write  <= EX_MEM_valid & EX_MEM_reg_write & ~mis;
        MEM_WB_mem_data   <= (is_load && !mis) ? ldata : 32'd0;
        MEM_WB_alu_out    <= EX_MEM_alu_out;
        MEM_WB_rd         <= EX_MEM_rd;
        MEM_WB_misalign   <= mis;
      end else begin
        MEM_WB_valid      <= 1'b0;
        MEM_WB_mem_to_reg <= 1'b0;
        MEM_WB_reg_write  <= 1'b0;
        MEM_WB_mem_data   <= 32'd0;
        MEM_WB_alu_out    <= 32'd0;
        MEM_WB_rd         <= 5'd0;
        MEM_WB_misalign   <= 1'b0;
      end
    end
  end

  // Memory holds its contents across reset; an aborted access never writes.
  always_ff @(posedge clk) begin
    if (!reset && done && is_store && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_param.sv
// Randomized bench for mem_stage_param: two instances (no wait / 3 waits)
// checked against a byte-addressed behavioural memory model.
module tb_mem_stage_param;

  typedef struct packed {
    logic        v, m2r, rw, mr, mw;
    logic [2:0]  f3;
    logic [31:0] alu, db;
    logic [4:0]  rd;
  } ex_t;

  typedef struct packed {
    logic        v, m2r, rw, mis;
    logic [31:0] md, alu;
    logic [4:0]  rd;
  } wb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ex_t  ex0 = '0;
  ex_t  ex3 = '0;

  logic        stall0, v0, m2r0, rw0, mis0;
  logic [31:0] md0, alu0;
  logic [4:0]  rd0;
  logic        stall3, v3, m2r3, rw3, mis3;
  logic [31:0] md3, alu3;
  logic [4:0]  rd3;

  logic [7:0] m0 [64];
  logic [7:0] m3 [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_param #(.DEPTH(16), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset),
    .EX_MEM_valid(ex0.v), .EX_MEM_mem_to_reg(ex0.m2r),
    .EX_MEM_reg_write(ex0.rw), .EX_MEM_mem_read(ex0.mr),
    .EX_MEM_mem_write(ex0.mw), .EX_MEM_funct3(ex0.f3),
    .EX_MEM_alu_out(ex0.alu), .EX_MEM_dataB(ex0.db),
    .EX_MEM_rd(ex0.rd), .mem_stall(stall0),
    .MEM_WB_valid(v0), .MEM_WB_mem_to_reg(m2r0),
    .MEM_WB_reg_write(rw0), .MEM_WB_mem_data(md0),
    .MEM_WB_alu_out(alu0), .MEM_WB_rd(rd0),
    .MEM_WB_misalign(mis0)
  );

  mem_stage_param #(.DEPTH(64), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset),
    .EX_MEM_valid(ex3.v), .EX_MEM_mem_to_reg(ex3.m2r),
    .EX_MEM_reg_write(ex3.rw), .EX_MEM_mem_read(ex3.mr),
    .EX_MEM_mem_write(ex3.mw), .EX_MEM_funct3(ex3.f3),
    .EX_MEM_alu_out(ex3.alu), .EX_MEM_dataB(ex3.db),
    .EX_MEM_rd(ex3.rd), .mem_stall(stall3),
    .MEM_WB_valid(v3), .MEM_WB_mem_to_reg(m2r3),
    .MEM_WB_reg_write(rw3), .MEM_WB_mem_data(md3),
    .MEM_WB_alu_out(alu3), .MEM_WB_rd(rd3),
    .MEM_WB_misalign(mis3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd8(input bit w3, input int a);
    return w3 ? m3[a] : m0[a];
  endfunction

  function automatic void wr8(input bit w3, input int a,
                              input logic [7:0] b);
    if (w3) m3[a] = b;
    else    m0[a] = b;
  endfunction

  // Reference: byte-addressed memory, size from funct3, wrap by modulo.
  function automatic wb_t model(input ex_t e, input bit w3);
    wb_t r;
    int nb, sz, a;
    bit mop, mis;
    logic [31:0] val;
    sz  = e.f3[1] ? 4 : (e.f3[0] ? 2 : 1);
    nb  = w3 ? 256 : 64;
    a   = int'(e.alu & 32'(nb - 1));
    mop = e.v && (e.mr || e.mw);
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = mop && (a % sz != 0);
`endif
    a     = a - (a % sz);
    r     = '0;
    r.v   = e.v;
    r.m2r = e.m2r;
    r.alu = e.alu;
    r.rd  = e.rd;
    r.mis = mis;
    r.rw  = e.v && e.rw && !mis;
    if (mop && !mis) begin
      if (e.mw) begin
        for (int i = 0; i < sz; i++) wr8(w3, a + i, e.db[8*i +: 8]);
      end else begin
        val = 32'd0;
        for (int i = 0; i < sz; i++) val[8*i +: 8] = rd8(w3, a + i);
        if (!e.f3[2] && sz < 4 && val[8*sz-1])
          val = val | ~((32'd1 << (8*sz)) - 32'd1);
        r.md = val;
      end
    end
    return r;
  endfunction

  function automatic ex_t op_st(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d);
    ex_t e = '0;
    e.v = 1'b1; e.mw = 1'b1; e.f3 = f3; e.alu = a; e.db = d;
    return e;
  endfunction

  function automatic ex_t op_ld(input logic [2:0] f3, input logic [31:0] a);
    ex_t e = '0;
    e.v = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1;
    e.f3 = f3; e.alu = a; e.rd = 5'd7;
    return e;
  endfunction

  function automatic ex_t op_rand(input bit w3);
    ex_t e;
    e.v   = $urandom_range(0, 7) != 0;
    e.m2r = 1'($urandom);
    e.rw  = 1'($urandom);
    e.mr  = 1'($urandom);
    e.mw  = $urandom_range(0, 2) == 0;
    e.f3  = 3'($urandom);
    e.alu = w3 ? 32'($urandom) & 32'h0000_03FF : 32'($urandom);
    e.db  = 32'($urandom);
    e.rd  = 5'($urandom);
    return e;
  endfunction

  task automatic check_wb(input string tag, input wb_t exp, input bit w3);
    wb_t got;
    if (w3) got = {v3, m2r3, rw3, mis3, md3, alu3, rd3};
    else    got = {v0, m2r0, rw0, mis0, md0, alu0, rd0};
    chk({tag, ".ctl"}, {28'd0, got.v, got.m2r, got.rw, got.mis},
        {28'd0, exp.v, exp.m2r, exp.rw, exp.mis});
    chk({tag, ".data"}, got.md, exp.md);
    chk({tag, ".alu"}, got.alu, exp.alu);
    chk({tag, ".rd"}, {27'd0, got.rd}, {27'd0, exp.rd});
  endtask

  // Called at negedge; returns at the next negedge with inputs idle.
  task automatic run0(input ex_t e);
    wb_t exp;
    ex0 = e;
    exp = model(e, 1'b0);
    #1 chk("u0.stall", {31'd0, stall0}, 32'd0);
    @(posedge clk);
    #1 check_wb("u0.wb", exp, 1'b0);
    @(negedge clk);
    ex0 = '0;
  endtask

  task automatic run3(input ex_t e);
    wb_t exp;
    bit  stl;
    ex3 = e;
    exp = model(e, 1'b1);
    stl = e.v && (e.mr || e.mw) && !exp.mis;
    if (stl) begin
      for (int k = 0; k < 3; k++) begin
        #1 chk("u3.stall_hi", {31'd0, stall3}, 32'd1);
        @(posedge clk);
        #1 chk("u3.bubble", {30'd0, v3, rw3}, 32'd0);
        @(negedge clk);
      end
    end
    #1 chk("u3.stall_lo", {31'd0, stall3}, 32'd0);
    @(posedge clk);
    #1 check_wb("u3.wb", exp, 1'b1);
    @(negedge clk);
    ex3 = '0;
  endtask

  initial begin
    ex_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.u0", {v0, m2r0, rw0, mis0, stall0, rd0, md0[0], alu0[0]}, 32'd0);
    chk("rst.u3", {v3, m2r3, rw3, mis3, stall3, rd3, md3[0], alu3[0]}, 32'd0);
    chk("rst.md", md0 | md3 | alu0 | alu3, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run0(op_st(3'b010, 32'(i * 4), 32'($urandom)));
    for (int i = 0; i < 64; i++) run3(op_st(3'b010, 32'(i * 4), 32'($urandom)));

    run0(op_st(3'b010, 32'h10, 32'hDEADBEEF));
    run0(op_ld(3'b010, 32'h10));
    chk("sw_lw", md0, 32'hDEADBEEF);

    run0(op_st(3'b010, 32'h20, 32'h000080F0));
    run0(op_ld(3'b000, 32'h20));
    chk("lb", md0, 32'hFFFFFFF0);
    run0(op_ld(3'b100, 32'h20));
    chk("lbu", md0, 32'h000000F0);
    run0(op_ld(3'b001, 32'h20));
    chk("lh", md0, 32'hFFFF80F0);
    run0(op_ld(3'b101, 32'h20));
    chk("lhu", md0, 32'h000080F0);

    run0(op_st(3'b010, 32'h30, 32'h11223344));
    run0(op_st(3'b000, 32'h31, 32'h000000AA));
    run0(op_ld(3'b010, 32'h30));
    chk("sb_merge", md0, 32'h1122AA44);

    e = op_st(3'b010, 32'h34, 32'hCAFEF00D);
    e.mr = 1'b1;
    run0(e);
    chk("rdwr_data", md0, 32'd0);
    run0(op_ld(3'b010, 32'h74));
    chk("wrap", md0, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) run0(op_rand(1'b0));

    run3(op_ld(3'b010, 32'h10));
    e = '0;
    e.v = 1'b1; e.rw = 1'b1; e.alu = 32'h1234; e.rd = 5'd3;
    run3(e);
    chk("add_after", alu3, 32'h1234);

    run3(op_st(3'b010, 32'h40, 32'h12345678));
    ex3 = op_st(3'b010, 32'h40, 32'h00000055);
    #1 chk("abort.stall", {31'd0, stall3}, 32'd1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 chk("abort.out", {30'd0, stall3, v3}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ex3 = '0;
    run3(op_ld(3'b010, 32'h40));
    chk("abort.mem", md3, 32'h12345678);

`ifdef MEM_MISALIGN_TRAP_EN
    run3(op_ld(3'b010, 32'h42));
    chk("mis.flag", {30'd0, mis3, rw3}, 32'd2);
    run3(op_st(3'b001, 32'h43, 32'h0000BEEF));
    run3(op_ld(3'b010, 32'h40));
    chk("mis.nowr", md3, 32'h12345678);
`endif

    for (int i = 0; i < 150; i++) run3(op_rand(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
